// File: rtl/gessm_dot_acc_pkg.sv
// Shared definitions for the gessm dot-product accumulation stage and later MAC variants.
package gessm_dot_acc_pkg;
  localparam int GESSM_PW    = 32;
  localparam int GESSM_AW    = 40;
  localparam int GESSM_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/gessm_sat_add.sv
// AW-bit unsigned saturating adder; a carry-out clamps the sum to all-ones.
module gessm_sat_add #(
  parameter int AW = 40
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          ovf
);
  logic [AW:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  assign ovf = raw[AW];
  assign sum = raw[AW] ? {AW{1'b1}} : raw[AW-1:0];
endmodule

// File: rtl/gessm_dot_acc.sv
// Sums LEN unsigned products into a saturating accumulator and hands the result
// out on a valid/ready port; one job in flight at a time.
module gessm_dot_acc
  import gessm_dot_acc_pkg::*;
#(
  parameter int PW    = GESSM_PW,
  parameter int AW    = GESSM_AW,
  parameter int LEN_W = GESSM_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  input  logic [PW-1:0]    p_data,
  output logic             p_ready,
  output logic             acc_valid,
  output logic [AW-1:0]    acc_data,
  output logic             acc_ovf,
  input  logic             acc_ready,
  output logic             busy
);
  state_e           state, state_nx;
  logic [LEN_W-1:0] cnt;
  logic [AW-1:0]    acc, sum, p_ext;
  logic             ovf, sum_ovf;
  logic             beat, last;

  assign p_ext = AW'(p_data);
  assign beat  = p_valid && (state == ST_ACCUM);
  assign last  = beat && (cnt == LEN_W'(1));

  gessm_sat_add #(.AW(AW)) u_add (
    .a   (acc),
    .b   (p_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (len == '0) ? ST_HOLD : ST_ACCUM;
      ST_ACCUM: if (last) state_nx = ST_HOLD;
      ST_HOLD:  if (acc_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // ovf is sticky per job; a saturated acc stays all-ones since any further add carries.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      acc <= '0;
      cnt <= len;
      ovf <= 1'b0;
    end else if (beat) begin
      acc <= sum;
      cnt <= cnt - LEN_W'(1);
      ovf <= ovf | sum_ovf;
    end
  end

  // Outputs are pure decodes of registered state, so no input reaches them combinationally.
  assign p_ready   = (state == ST_ACCUM);
  assign acc_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);
  assign acc_data  = acc;
  assign acc_ovf   = ovf;
endmodule

// File: tb/tb_gessm_dot_acc.sv
// Drives two accumulators (AW=40 and AW=33) with identical jobs and checks both
// against a sum-then-clamp reference.
module tb_gessm_dot_acc;
  logic        clk = 1'b0;
  logic        rst, start, p_valid, acc_ready;
  logic [7:0]  len;
  logic [31:0] p_data;

  logic        a_p_ready, a_acc_valid, a_acc_ovf, a_busy;
  logic [39:0] a_acc_data;
  logic        b_p_ready, b_acc_valid, b_acc_ovf, b_busy;
  logic [32:0] b_acc_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] pq[$];

  always #5 clk = ~clk;

  gessm_dot_acc #(.PW(32), .AW(40), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .p_valid(p_valid), .p_data(p_data),
    .p_ready(a_p_ready), .acc_valid(a_acc_valid), .acc_data(a_acc_data), .acc_ovf(a_acc_ovf),
    .acc_ready(acc_ready), .busy(a_busy)
  );

  gessm_dot_acc #(.PW(32), .AW(33), .LEN_W(8)) dut33 (
    .clk(clk), .rst(rst), .start(start), .len(len), .p_valid(p_valid), .p_data(p_data),
    .p_ready(b_p_ready), .acc_valid(b_acc_valid), .acc_data(b_acc_data), .acc_ovf(b_acc_ovf),
    .acc_ready(acc_ready), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat_model(input logic [63:0] tot, input int aw);
    logic [63:0] mx;
    mx = (64'd1 << aw) - 64'd1;
    return (tot > mx) ? mx : tot;
  endfunction

  task automatic chk_ctrl(input string tag, input logic pr, input logic av, input logic bz);
    chk({tag, ".p_ready40"}, 64'(a_p_ready), 64'(pr));
    chk({tag, ".p_ready33"}, 64'(b_p_ready), 64'(pr));
    chk({tag, ".acc_valid40"}, 64'(a_acc_valid), 64'(av));
    chk({tag, ".acc_valid33"}, 64'(b_acc_valid), 64'(av));
    chk({tag, ".busy40"}, 64'(a_busy), 64'(bz));
    chk({tag, ".busy33"}, 64'(b_busy), 64'(bz));
  endtask

  task automatic chk_result(input string tag, input logic [63:0] tot);
    chk({tag, ".data40"}, 64'(a_acc_data), sat_model(tot, 40));
    chk({tag, ".ovf40"},  64'(a_acc_ovf),  64'(tot > sat_model(tot, 40)));
    chk({tag, ".data33"}, 64'(b_acc_data), sat_model(tot, 33));
    chk({tag, ".ovf33"},  64'(b_acc_ovf),  64'(tot > sat_model(tot, 33)));
  endtask

  // Runs one job from the products in pq; start/p_valid noise is injected where it must be ignored.
  task automatic run_job(input string tag, input int gap, input int bp);
    logic [63:0] tot;
    int          n;
    n   = pq.size();
    tot = 0;
    foreach (pq[i]) tot += 64'(pq[i]);
    @(negedge clk);
    start = 1'b1; len = 8'(n); p_valid = 1'b1; p_data = $urandom; acc_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; p_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_ctrl({tag, ".accum"}, 1'b1, 1'b0, 1'b1);
      p_valid = 1'b1; p_data = pq[i];
      start = 1'($urandom); len = 8'($urandom);
      @(negedge clk);
      p_valid = 1'b0;
      for (int g = 0; g < gap && i < n - 1; g++) begin
        p_data = $urandom;
        @(negedge clk);
      end
    end
    for (int h = 0; h <= bp; h++) begin
      chk_ctrl({tag, ".hold"}, 1'b0, 1'b1, 1'b1);
      chk_result({tag, ".hold"}, tot);
      p_valid = 1'($urandom); p_data = $urandom;
      start = 1'($urandom); len = 8'($urandom);
      acc_ready = (h == bp);
      if (h < bp) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0; p_valid = 1'b0; acc_ready = 1'b0;
    chk_ctrl({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
    chk_result({tag, ".idle"}, tot);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; p_valid = 1'b0; p_data = '0; acc_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.data40", 64'(a_acc_data), 64'd0);
    chk("reset.data33", 64'(b_acc_data), 64'd0);

    pq = '{32'd10, 32'd20, 32'd30};
    run_job("basic", 0, 0);

    pq = '{32'hFFFF_FFFF, 32'd1};
    run_job("bubble_bp", 2, 5);

    pq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_job("saturate", 0, 1);
    pq = '{32'd5};
    run_job("after_sat", 0, 0);

    pq = {};
    run_job("empty", 0, 2);

    // Reset in the middle of a job discards it.
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      p_valid = 1'b1; p_data = $urandom;
      @(negedge clk);
    end
    p_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_ctrl("midreset", 1'b0, 1'b0, 1'b0);
    pq = '{32'd7};
    run_job("after_reset", 0, 0);

    // Random jobs, including a full-length job of maximal products.
    for (int j = 0; j < 24; j++) begin
      int n;
      n = $urandom_range(0, 10);
      pq = {};
      for (int k = 0; k < n; k++)
        pq.push_back(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      run_job("rand", $urandom_range(0, 2), $urandom_range(0, 3));
    end
    pq = {};
    for (int k = 0; k < 255; k++) pq.push_back(32'hFFFF_FFFF);
    run_job("maxlen", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
